// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, EX redirect squash,
// multi-cycle multiply hold, plus saturating stall/flush counters for perf debug.
module pipeline_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [4:0]       nr1_id_i,
  input  logic [4:0]       nr2_id_i,
  input  logic             use_rs1_id_i,
  input  logic             use_rs2_id_i,
  input  logic             mem_rd_ex_i,
  input  logic [4:0]       regd_ex_i,
  input  logic             mul_ex_i,
  input  logic             redirect_ex_i,
  input  logic             clr_cnt_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_flush_o,
  output logic             exmem_bubble_o,
  output logic             mul_busy_o,
  output logic             mul_done_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic {RUN, BUSY} state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_bubble;
    logic mul_busy;
    logic mul_done;
  } ctl_t;

  localparam ctl_t CTL_DEF  = ctl_t'(8'b1101_0000);
  localparam ctl_t CTL_RST  = ctl_t'(8'b0010_1100);
  localparam ctl_t CTL_HOLD = ctl_t'(8'b0000_0110);

  // The start cycle is the first hold cycle, so the remaining hold count is MUL_LAT-2.
  localparam logic [3:0] MUL_CNT_INIT = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  ctl_t       ctl;
  logic       redir_hit;
  logic       load_use;

  assign load_use = mem_rd_ex_i && (regd_ex_i != 5'd0) &&
                    ((use_rs1_id_i && (nr1_id_i == regd_ex_i)) ||
                     (use_rs2_id_i && (nr2_id_i == regd_ex_i)));

  always_comb begin
    ctl       = CTL_DEF;
    state_nxt = state;
    cnt_nxt   = cnt;
    redir_hit = 1'b0;
    if (reset_i) begin
      ctl = CTL_RST;
    end else begin
      case (state)
        BUSY: begin
          if (cnt != 4'd0) begin
            ctl     = CTL_HOLD;
            cnt_nxt = cnt - 4'd1;
          end else begin
            ctl.mul_done = 1'b1;
            state_nxt    = RUN;
          end
        end
        RUN: begin
          // Redirect wins over load-use: the stalled ID instruction is wrong-path anyway.
          if (redirect_ex_i) begin
            ctl.ifid_flush = 1'b1;
            ctl.idex_flush = 1'b1;
            redir_hit      = 1'b1;
          end else if (mul_ex_i) begin
            if (MUL_LAT > 1) begin
              ctl       = CTL_HOLD;
              cnt_nxt   = MUL_CNT_INIT;
              state_nxt = BUSY;
            end else begin
              ctl.mul_done = 1'b1;
            end
          end else if (load_use) begin
            ctl.pc_write   = 1'b0;
            ctl.ifid_write = 1'b0;
            ctl.idex_flush = 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= RUN;
      cnt         <= 4'd0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (clr_cnt_i) begin
        stall_cnt_o <= '0;
        flush_cnt_o <= '0;
      end else begin
        if (!ctl.pc_write && (stall_cnt_o != '1))
          stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        if (redir_hit && (flush_cnt_o != '1))
          flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
    end
  end

  assign pc_write_o     = ctl.pc_write;
  assign ifid_write_o   = ctl.ifid_write;
  assign ifid_flush_o   = ctl.ifid_flush;
  assign idex_write_o   = ctl.idex_write;
  assign idex_flush_o   = ctl.idex_flush;
  assign exmem_bubble_o = ctl.exmem_bubble;
  assign mul_busy_o     = ctl.mul_busy;
  assign mul_done_o     = ctl.mul_done;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with an expected-result queue; a CNT_W=4 copy
// checks saturation and a MUL_LAT=1 copy checks the single-cycle multiply path.
module tb_pipeline_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [4:0] nr1_id_i = '0, nr2_id_i = '0, regd_ex_i = '0;
  logic       use_rs1_id_i = 0, use_rs2_id_i = 0, mem_rd_ex_i = 0;
  logic       mul_ex_i = 0, redirect_ex_i = 0, clr_cnt_i = 0;

  logic        pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_b, mbusy, mdone;
  logic [15:0] stall_cnt, flush_cnt;
  logic        pc_w4, ifid_w4, ifid_f4, idex_w4, idex_f4, exmem_b4, mbusy4, mdone4;
  logic [3:0]  stall_cnt4, flush_cnt4;
  logic        pc_w1, ifid_w1, ifid_f1, idex_w1, idex_f1, exmem_b1, mbusy1, mdone1;
  logic [15:0] stall_cnt1, flush_cnt1;

  pipeline_hazard_ctrl #(.MUL_LAT(4), .CNT_W(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .nr1_id_i(nr1_id_i), .nr2_id_i(nr2_id_i),
    .use_rs1_id_i(use_rs1_id_i), .use_rs2_id_i(use_rs2_id_i), .mem_rd_ex_i(mem_rd_ex_i),
    .regd_ex_i(regd_ex_i), .mul_ex_i(mul_ex_i), .redirect_ex_i(redirect_ex_i),
    .clr_cnt_i(clr_cnt_i), .pc_write_o(pc_w), .ifid_write_o(ifid_w), .ifid_flush_o(ifid_f),
    .idex_write_o(idex_w), .idex_flush_o(idex_f), .exmem_bubble_o(exmem_b),
    .mul_busy_o(mbusy), .mul_done_o(mdone), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt));

  pipeline_hazard_ctrl #(.MUL_LAT(4), .CNT_W(4)) dut_sat (
    .clk_i(clk_i), .reset_i(reset_i), .nr1_id_i(nr1_id_i), .nr2_id_i(nr2_id_i),
    .use_rs1_id_i(use_rs1_id_i), .use_rs2_id_i(use_rs2_id_i), .mem_rd_ex_i(mem_rd_ex_i),
    .regd_ex_i(regd_ex_i), .mul_ex_i(mul_ex_i), .redirect_ex_i(redirect_ex_i),
    .clr_cnt_i(clr_cnt_i), .pc_write_o(pc_w4), .ifid_write_o(ifid_w4), .ifid_flush_o(ifid_f4),
    .idex_write_o(idex_w4), .idex_flush_o(idex_f4), .exmem_bubble_o(exmem_b4),
    .mul_busy_o(mbusy4), .mul_done_o(mdone4), .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4));

  pipeline_hazard_ctrl #(.MUL_LAT(1), .CNT_W(16)) dut_m1 (
    .clk_i(clk_i), .reset_i(reset_i), .nr1_id_i(nr1_id_i), .nr2_id_i(nr2_id_i),
    .use_rs1_id_i(use_rs1_id_i), .use_rs2_id_i(use_rs2_id_i), .mem_rd_ex_i(mem_rd_ex_i),
    .regd_ex_i(regd_ex_i), .mul_ex_i(mul_ex_i), .redirect_ex_i(redirect_ex_i),
    .clr_cnt_i(clr_cnt_i), .pc_write_o(pc_w1), .ifid_write_o(ifid_w1), .ifid_flush_o(ifid_f1),
    .idex_write_o(idex_w1), .idex_flush_o(idex_f1), .exmem_bubble_o(exmem_b1),
    .mul_busy_o(mbusy1), .mul_done_o(mdone1), .stall_cnt_o(stall_cnt1), .flush_cnt_o(flush_cnt1));

  always #5 clk_i = ~clk_i;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_bubble, mul_busy, mul_done}
  localparam logic [7:0] DEF   = 8'b1101_0000;
  localparam logic [7:0] RST   = 8'b0010_1100;
  localparam logic [7:0] HOLD  = 8'b0000_0110;
  localparam logic [7:0] REL   = 8'b1101_0001;
  localparam logic [7:0] REDIR = 8'b1111_1000;
  localparam logic [7:0] LU    = 8'b0001_1000;

  typedef struct {
    string       tag;
    logic [7:0]  ctl;
    logic [15:0] stall;
    logic [15:0] flush;
    logic [3:0]  stall4;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0, n_err = 0;
  logic [15:0] m_stall = '0, m_flush = '0;
  logic [3:0]  m_stall4 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven (edge+1); push expectation, compare mid-cycle, then advance.
  task automatic step(input string tag, input logic [7:0] ectl);
    exp_t e, o;
    if (reset_i) begin
      m_stall = '0; m_flush = '0; m_stall4 = '0;
    end
    e.tag = tag; e.ctl = ectl; e.stall = m_stall; e.flush = m_flush; e.stall4 = m_stall4;
    sb.push_back(e);
    #3;
    o = sb.pop_front();
    chk({o.tag, ".ctl"}, 32'({pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_b, mbusy, mdone}),
        32'(o.ctl));
    chk({o.tag, ".stall"}, 32'(stall_cnt), 32'(o.stall));
    chk({o.tag, ".flush"}, 32'(flush_cnt), 32'(o.flush));
    chk({o.tag, ".stall4"}, 32'(stall_cnt4), 32'(o.stall4));
    if (!reset_i) begin
      if (clr_cnt_i) begin
        m_stall = '0; m_flush = '0; m_stall4 = '0;
      end else begin
        if (!ectl[7]) begin
          m_stall = m_stall + 16'd1;
          if (m_stall4 != 4'hF) m_stall4 = m_stall4 + 4'd1;
        end
        if (ectl == REDIR) m_flush = m_flush + 16'd1;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_lu(input logic en);
    mem_rd_ex_i = en; regd_ex_i = 5'd5; nr1_id_i = 5'd5; use_rs1_id_i = en;
  endtask

  initial begin
    #1;
    step("reset0", RST);
    step("reset1", RST);
    reset_i = 1'b0;
    step("idle", DEF);

    set_lu(1);
    step("lu", LU);
    set_lu(0);
    step("lu_after", DEF);
    mem_rd_ex_i = 1; regd_ex_i = 5'd0; nr1_id_i = 5'd0; use_rs1_id_i = 1;
    step("lu_x0", DEF);
    regd_ex_i = 5'd5; nr1_id_i = 5'd5; use_rs1_id_i = 0;
    step("lu_nouse", DEF);
    nr2_id_i = 5'd5; use_rs2_id_i = 1;
    step("lu_rs2", LU);
    use_rs2_id_i = 0; nr2_id_i = 5'd0;

    set_lu(1); redirect_ex_i = 1;
    step("redir_lu", REDIR);
    set_lu(0); redirect_ex_i = 0;
    step("redir_after", DEF);

    mul_ex_i = 1;
    #2;
    chk("m1_done", 32'({pc_w1, idex_w1, mbusy1, mdone1}), 32'(4'b1101));
    step("mul_c0", HOLD);
    step("mul_c1", HOLD);
    step("mul_c2", HOLD);
    step("mul_c3", REL);
    mul_ex_i = 0;
    step("mul_after", DEF);

    mul_ex_i = 1;
    step("b2b_a0", HOLD);
    redirect_ex_i = 1; set_lu(1);
    step("b2b_a1", HOLD);
    redirect_ex_i = 0; set_lu(0);
    step("b2b_a2", HOLD);
    step("b2b_arel", REL);
    step("b2b_b0", HOLD);
    redirect_ex_i = 1;
    step("b2b_b1", HOLD);
    redirect_ex_i = 0;
    step("b2b_b2", HOLD);
    step("b2b_brel", REL);
    mul_ex_i = 0;
    step("b2b_after", DEF);

    mul_ex_i = 1;
    step("rmid_c0", HOLD);
    reset_i = 1;
    step("rmid_rst", RST);
    reset_i = 0; mul_ex_i = 0;
    step("rmid_after", DEF);
    step("rmid_idle", DEF);

    set_lu(1);
    for (int i = 0; i < 20; i++) step("sat_lu", LU);
    clr_cnt_i = 1;
    step("sat_clr", LU);
    clr_cnt_i = 0; set_lu(0);
    step("sat_cleared", DEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. It sequences the IF/ID, ID/EX and EX/MEM pipeline registers and the PC. It detects load-use hazards, squashes wrong-path instructions on a taken branch or jump resolved in EX, and holds the pipeline while the multi-cycle multiplier occupies EX. It also keeps saturating stall and flush counters for performance debug.

## Interface
- MUL_LAT, 4: total EX occupancy of a multiply in cycles; legal values are 1..16.
- CNT_W, 16: width of the performance counters.

- clk_i  in  1  pipeline clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- nr1_id_i  in  5  rs1 index of the instruction in ID.
- nr2_id_i  in  5  rs2 index of the instruction in ID.
- use_rs1_id_i  in  1  the ID instruction reads rs1.
- use_rs2_id_i  in  1  the ID instruction reads rs2.
- mem_rd_ex_i  in  1  the EX instruction is a load.
- regd_ex_i  in  5  destination register of the EX instruction.
- mul_ex_i  in  1  the EX instruction is a multiply.
- redirect_ex_i  in  1  a taken branch or jal/jalr is resolved in EX this cycle.
- clr_cnt_i  in  1  synchronous clear of both counters.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  IF/ID loads a NOP.
- idex_write_o  out  1  ID/EX load enable.
- idex_flush_o  out  1  ID/EX loads a bubble (all control fields zero).
- exmem_bubble_o  out  1  EX/MEM loads a bubble.
- mul_busy_o  out  1  multiply hold is in progress.
- mul_done_o  out  1  the multiply result is valid in EX this cycle.
- stall_cnt_o  out  CNT_W  number of cycles with pc_write_o=0, excluding reset.
- flush_cnt_o  out  CNT_W  number of redirect cycles.

## Operation
- State: FSM {RUN, BUSY}, plus a 4-bit down-counter `cnt`.
- Default outputs, all writes enabled:
  - pc_write_o, ifid_write_o, idex_write_o = 1.
  - ifid_flush_o, idex_flush_o, exmem_bubble_o, mul_busy_o, mul_done_o = 0.
- Outputs are combinational from state and inputs. Cases are evaluated in this priority order:
  1. reset_i high: pc_write_o, ifid_write_o, idex_write_o = 0; ifid_flush_o, idex_flush_o, exmem_bubble_o = 1; mul_busy_o, mul_done_o = 0; both counters = 0; state RUN; cnt = 0.
  2. BUSY with cnt != 0 (hold): pc_write_o, ifid_write_o, idex_write_o = 0; exmem_bubble_o = 1; mul_busy_o = 1. cnt decrements.
  3. BUSY with cnt == 0 (release): default outputs, with mul_done_o = 1. Next state is RUN.
  4. RUN with redirect_ex_i (redirect): ifid_flush_o = 1 and idex_flush_o = 1; all writes stay 1.
  5. RUN with mul_ex_i and MUL_LAT > 1 (mul start): outputs as in the hold case. cnt <= MUL_LAT-2; next state BUSY.
  6. RUN with mul_ex_i and MUL_LAT == 1: default outputs with mul_done_o = 1. No state change.
  7. RUN with load-use (load-use stall): pc_write_o = 0; ifid_write_o = 0; idex_flush_o = 1 (ID/EX is written with a bubble). Load-use is mem_rd_ex_i && regd_ex_i != 0 && at least one of:
     - use_rs1_id_i && nr1_id_i == regd_ex_i
     - use_rs2_id_i && nr2_id_i == regd_ex_i
- redirect_ex_i and load-use inputs are ignored in BUSY. In RUN, redirect beats load-use: the ID instruction is squashed anyway.
- A multiply immediately after a multiply re-enters BUSY from RUN. No dead cycle is added beyond the release cycle.
- Counters:
  - Each counter saturates at all-ones.
  - clr_cnt_i has priority over increment.
  - stall_cnt_o increments on every non-reset cycle with pc_write_o = 0.
  - flush_cnt_o increments on every cycle in the redirect case.

## Timing
- Load-use costs exactly 1 stall cycle. In the next cycle the load has moved to MEM, so the condition clears by construction.
- Redirect takes effect in the same cycle it is seen. The two wrong-path instructions (in IF/ID and ID/EX) become NOPs at the next edge. There is no stall.
- Multiply, MUL_LAT = N > 1:
  - The multiply enters EX in cycle 0.
  - Hold is asserted in cycles 0..N-2 (N-1 cycles).
  - mul_done_o = 1 in cycle N-1, and the pipeline advances at the end of that cycle.
  - stall_cnt_o grows by N-1.
- Reset assertion mid-multiply immediately forces the reset outputs and returns the FSM to RUN. After deassertion, the first edge resumes normal RUN behaviour.

## Test plan
- Load-use: regd_ex_i=5, mem_rd_ex_i=1, nr1_id_i=5, use_rs1_id_i=1 -> one cycle of pc_write_o=0, ifid_write_o=0, idex_flush_o=1; stall_cnt_o=1. Repeat with regd_ex_i=0 or use_rs1_id_i=0 -> no stall.
- Redirect: redirect_ex_i=1 for 1 cycle, with a load-use hazard present at the same time -> ifid_flush_o=1, idex_flush_o=1, pc_write_o=1; flush_cnt_o=1; stall_cnt_o unchanged.
- Multiply, MUL_LAT=4: mul_ex_i=1 held -> hold (pc/ifid/idex writes 0, exmem_bubble_o=1, mul_busy_o=1) for cycles 0-2; mul_done_o=1 in cycle 3; stall_cnt_o=3.
- Back-to-back multiplies: two consecutive multiplies -> two 3-cycle holds separated only by the release cycle; redirect_ex_i pulsed during hold is ignored (flush_cnt_o=0).
- Reset mid-hold: assert reset_i in cycle 1 of a multiply -> outputs take the reset values asynchronously and counters read 0; after release, default outputs and mul_busy_o=0.
- Saturation/clear: CNT_W=4 with 20 stall cycles -> stall_cnt_o=15; clr_cnt_i=1 together with a stall -> stall_cnt_o=0 the next cycle.
